dma_sync_fifo: RTL and testbench

DMA_SYNC_FIFO -- requirements
Module: dma_sync_fifo

---
 rtl/dma_sync_fifo_pkg.sv | 19 +
 rtl/dma_fifo_defs.vh | 14 +
 rtl/dma_fifo_ram.sv | 24 ++
 rtl/dma_sync_fifo.sv | 92 +++++++++
 tb/tb_dma_sync_fifo.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/dma_sync_fifo_pkg.sv
// Package exposing the FIFO defaults and sizing helpers to the RTL.
package dma_sync_fifo_pkg;
`include "dma_fifo_defs.vh"

  localparam int DEF_DW    = `DMA_FIFO_DEF_DW;
  localparam int DEF_AW    = `DMA_FIFO_DEF_AW;
  localparam int DEF_AF_TH = `DMA_FIFO_DEF_AF_TH;
  localparam int DEF_AE_TH = `DMA_FIFO_DEF_AE_TH;
  localparam int DEF_FWFT  = `DMA_FIFO_DEF_FWFT;

  function automatic int fifo_depth(input int aw);
    return `DMA_FIFO_DEPTH(aw);
  endfunction

  // Pointers carry one extra wrap bit to tell full from empty.
  function automatic int ptr_width(input int aw);
    return `DMA_FIFO_PTR_W(aw);
  endfunction
endpackage

// File: rtl/dma_fifo_defs.vh
// Shared defaults and depth/pointer-width helpers for the DMA synchronous FIFO.
`ifndef DMA_FIFO_DEFS_VH
`define DMA_FIFO_DEFS_VH

`define DMA_FIFO_DEF_DW    32
`define DMA_FIFO_DEF_AW    4
`define DMA_FIFO_DEF_AF_TH 12
`define DMA_FIFO_DEF_AE_TH 2
`define DMA_FIFO_DEF_FWFT  1

`define DMA_FIFO_DEPTH(aw) (1 << (aw))
`define DMA_FIFO_PTR_W(aw) ((aw) + 1)

`endif

// File: rtl/dma_fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read, no reset.
module dma_fifo_ram
  import dma_sync_fifo_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  localparam int DEPTH = fifo_depth(AW);

  logic [DW-1:0] mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/dma_sync_fifo.sv
// Single-clock DMA FIFO with wrap-bit pointers, threshold flags, sticky errors
// and either show-ahead (FWFT=1) or registered (FWFT=0) read data.
module dma_sync_fifo
  import dma_sync_fifo_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int AW    = DEF_AW,
  parameter int AF_TH = DEF_AF_TH,
  parameter int AE_TH = DEF_AE_TH,
  parameter int FWFT  = DEF_FWFT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          wr_en,
  input  logic [DW-1:0] din,
  input  logic          rd_en,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          underflow
);
  localparam int PW = ptr_width(AW);
  localparam logic [PW-1:0] AF_CNT = PW'(AF_TH);
  localparam logic [PW-1:0] AE_CNT = PW'(AE_TH);

  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          wr_acc;
  logic          rd_acc;
  logic [DW-1:0] ram_rdata;

  // Flags come straight from the registered pointers.
  assign empty        = (wptr == rptr);
  assign full         = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
  assign count        = wptr - rptr;
  assign almost_full  = (count >= AF_CNT);
  assign almost_empty = (count <= AE_CNT);

  // A flush cycle ignores both requests.
  assign wr_acc = wr_en && !full && !clr;
  assign rd_acc = rd_en && !empty && !clr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clr) begin
      wptr      <= '0;
      rptr      <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wptr <= wptr + PW'(1);
      if (rd_acc) rptr <= rptr + PW'(1);
      if (wr_en && full) overflow <= 1'b1;
      if (rd_en && empty) underflow <= 1'b1;
    end
  end

  dma_fifo_ram #(.DW(DW), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wptr[AW-1:0]),
    .wdata (din),
    .raddr (rptr[AW-1:0]),
    .rdata (ram_rdata)
  );

  if (FWFT != 0) begin : g_fwft
    assign dout       = ram_rdata;
    assign dout_valid = !empty;
  end else begin : g_reg
    // dout holds the last popped word; dout_valid pulses for one cycle per read.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        dout       <= '0;
        dout_valid <= 1'b0;
      end else begin
        dout_valid <= rd_acc;
        if (rd_acc) dout <= ram_rdata;
      end
    end
  end
endmodule

// File: tb/tb_dma_sync_fifo.sv
// Randomized bench comparing show-ahead and registered-read FIFO instances
// against a queue-based model of occupancy, flags and read data.
module tb_dma_sync_fifo;
  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int AF_TH = 12;
  localparam int AE_TH = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clr = 1'b0;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] din = '0;

  logic [DW-1:0] f_dout, r_dout;
  logic          f_dv, r_dv;
  logic          f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
  logic          r_full, r_empty, r_af, r_ae, r_ovf, r_udf;
  logic [AW:0]   f_count, r_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] exp_q[$];
  logic          m_ovf, m_udf, m_dv0;
  logic [DW-1:0] m_dout0;

  always #5 clk = ~clk;

  dma_sync_fifo #(.DW(DW), .AW(AW), .AF_TH(AF_TH), .AE_TH(AE_TH), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .dout(f_dout), .dout_valid(f_dv), .full(f_full), .empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
    .overflow(f_ovf), .underflow(f_udf)
  );

  dma_sync_fifo #(.DW(DW), .AW(AW), .AF_TH(AF_TH), .AE_TH(AE_TH), .FWFT(0)) u_reg (
    .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .dout(r_dout), .dout_valid(r_dv), .full(r_full), .empty(r_empty),
    .almost_full(r_af), .almost_empty(r_ae), .count(r_count),
    .overflow(r_ovf), .underflow(r_udf)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string ph);
    int sz;
    sz = exp_q.size();
    check({ph, " count"},  64'(f_count), 64'(sz));
    check({ph, " empty"},  64'(f_empty), 64'(sz == 0));
    check({ph, " full"},   64'(f_full),  64'(sz == DEPTH));
    check({ph, " af"},     64'(f_af),    64'(sz >= AF_TH));
    check({ph, " ae"},     64'(f_ae),    64'(sz <= AE_TH));
    check({ph, " ovf"},    64'(f_ovf),   64'(m_ovf));
    check({ph, " udf"},    64'(f_udf),   64'(m_udf));
    check({ph, " f_dv"},   64'(f_dv),    64'(sz != 0));
    if (sz != 0) check({ph, " f_dout"}, 64'(f_dout), 64'(exp_q[0]));
    check({ph, " r_count"}, 64'(r_count), 64'(sz));
    check({ph, " r_full"},  64'(r_full),  64'(sz == DEPTH));
    check({ph, " r_ovf"},   64'(r_ovf),   64'(m_ovf));
    check({ph, " r_udf"},   64'(r_udf),   64'(m_udf));
    check({ph, " r_dv"},    64'(r_dv),    64'(m_dv0));
    check({ph, " r_dout"},  64'(r_dout),  64'(m_dout0));
  endtask

  // One clock of stimulus; the model applies the FIFO rules to its queue.
  task automatic step(input string ph, input logic w, input logic r, input logic c,
                      input logic [DW-1:0] d);
    int sz;
    logic do_w, do_r;
    wr_en = w; rd_en = r; clr = c; din = d;
    sz   = exp_q.size();
    do_w = w && !c && (sz < DEPTH);
    do_r = r && !c && (sz > 0);
    @(posedge clk);
    #1;
    if (c) begin
      exp_q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
      m_dv0 = 1'b0;
    end else begin
      if (w && sz == DEPTH) m_ovf = 1'b1;
      if (r && sz == 0) m_udf = 1'b1;
      m_dv0 = do_r;
      if (do_r) m_dout0 = exp_q.pop_front();
      if (do_w) exp_q.push_back(d);
    end
    wr_en = 1'b0; rd_en = 1'b0; clr = 1'b0;
    check_all(ph);
  endtask

  // Asynchronous reset: flags must drop before any clock edge arrives.
  task automatic do_reset(input string ph);
    rst = 1'b1;
    #2;
    exp_q.delete();
    m_ovf = 1'b0; m_udf = 1'b0; m_dv0 = 1'b0; m_dout0 = '0;
    check_all({ph, " async"});
    @(posedge clk);
    #1;
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; clr = 1'b0;
    check_all({ph, " released"});
  endtask

  initial begin
    int bias_w, bias_r;
    do_reset("init");

    for (int i = 1; i <= 16; i++) step("fill", 1'b1, 1'b0, 1'b0, DW'(i));
    step("overflow", 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF);
    for (int i = 0; i < 16; i++) step("drain", 1'b0, 1'b1, 1'b0, '0);
    step("underflow", 1'b0, 1'b1, 1'b0, '0);
    step("clr_flags", 1'b0, 1'b0, 1'b1, '0);

    for (int i = 0; i < 5; i++) step("pre5", 1'b1, 1'b0, 1'b0, $urandom);
    for (int i = 0; i < 40; i++) step("steady", 1'b1, 1'b1, 1'b0, $urandom);
    for (int i = 0; i < 5; i++) step("post5", 1'b0, 1'b1, 1'b0, '0);

    step("a5_wr", 1'b1, 1'b0, 1'b0, 32'hA5A5_A5A5);
    step("a5_rd", 1'b0, 1'b1, 1'b0, '0);
    step("a5_hold", 1'b0, 1'b0, 1'b0, '0);

    for (int i = 0; i < 9; i++) step("fill9", 1'b1, 1'b0, 1'b0, $urandom);
    step("clr_wr", 1'b1, 1'b0, 1'b1, 32'h1234_5678);

    for (int i = 0; i < 7; i++) step("burst", 1'b1, 1'b0, 1'b0, $urandom);
    do_reset("mid_burst");

    bias_w = 50; bias_r = 50;
    for (int i = 0; i < 600; i++) begin
      if (i % 60 == 0) begin
        bias_w = $urandom_range(15, 90);
        bias_r = $urandom_range(15, 90);
      end
      if ($urandom_range(0, 199) == 0) do_reset("rand_rst");
      else step("rand", 1'($urandom_range(0, 99) < bias_w),
                1'($urandom_range(0, 99) < bias_r),
                1'($urandom_range(0, 99) < 2), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
